// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out and signed overflow.
// Carry chain is built from explicit 1-bit full-adder cells, bit 0 to bit WIDTH-1.

module rca_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic prop;

  assign prop    = a_i ^ b_i;
  assign sum_o   = prop ^ c_i;
  assign carry_o = (a_i & b_i) | (c_i & prop);

endmodule

module ripple_carry_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_comb;
  logic             cout_comb;
  logic             ovf_comb;

  logic [WIDTH-1:0] s_d,    s_q;
  logic             cout_d, cout_q;
  logic             ovf_d,  ovf_q;
  logic             vld_d,  vld_q;

  assign carry[0] = cin;

  // Carry ripples strictly upward through one cell per bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    rca_full_adder u_fa (
      .a_i     (A[i]),
      .b_i     (B[i]),
      .c_i     (carry[i]),
      .sum_o   (s_comb[i]),
      .carry_o (carry[i+1])
    );
  end

  assign cout_comb = carry[WIDTH];
  assign ovf_comb  = carry[WIDTH] ^ carry[WIDTH-1];

  // Result registers load only on a valid input; valid flag is a plain delay.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = s_comb;
      cout_d = cout_comb;
      ovf_d  = ovf_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and exhaustive check of the 4-bit registered ripple-carry adder.
// Observed vectors are packed as {out_valid, cout, ovf, s}.

module tb_ripple_carry_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       ovf;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  ripple_carry_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got {vld,cout,ovf,s}=%b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {out_valid, cout, ovf, s};
  endfunction

  // One valid operation: drive on the falling edge, check just after the next rising edge.
  task automatic op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                    input logic ci, input logic [6:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = ci;
    @(posedge clk);
    #1;
    check(tag, outs(), exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset holds everything at zero even with valid random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 4'($urandom_range(15));
      b = 4'($urandom_range(15));
      cin = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      check("reset_hold", outs(), 7'b0_0_0_0000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    op("zero",        4'd0,     4'd0,     1'b0, 7'b1_0_0_0000);
    op("one_plus_3",  4'd1,     4'd3,     1'b0, 7'b1_0_0_0100);
    op("m3_plus_5",   4'b1101,  4'b0101,  1'b0, 7'b1_1_0_0010);
    op("2_plus_m5",   4'b0010,  4'b1011,  1'b0, 7'b1_0_0_1101);
    op("ones_cin",    4'b1111,  4'b0000,  1'b1, 7'b1_1_0_0000);
    op("min_plus_min",4'b1000,  4'b1000,  1'b0, 7'b1_1_1_0000);
    op("max_plus_1",  4'b0111,  4'b0001,  1'b0, 7'b1_0_1_1000);

    // Invalid inputs must not disturb the held result.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = 4'(i + 3);
      b = 4'(9 - i);
      cin = 1'(i);
      @(posedge clk);
      #1;
      check("hold", outs(), 7'b0_0_1_1000);
    end

    op("pre_reset",   4'd3,     4'd4,     1'b0, 7'b1_0_0_0111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 7'b0_0_0_0000);
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd6;
    @(posedge clk);
    #1;
    check("reset_edge", outs(), 7'b0_0_0_0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Every A, B, cin combination, back to back.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [4:0] u;
          int sa, sb, sr;
          logic v;
          u  = 5'(ai) + 5'(bi) + 5'(ci);
          sa = (ai > 7) ? ai - 16 : ai;
          sb = (bi > 7) ? bi - 16 : bi;
          sr = sa + sb + ci;
          v  = (sr > 7) || (sr < -8);
          op("exhaustive", 4'(ai), 4'(bi), 1'(ci), {1'b1, u[4], v, u[3:0]});
        end
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_idle", {out_valid, 6'd0}, 7'b0_0_0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

Registered N-bit ripple-carry adder (default 4 bits) computing `A + B + cin` with carry-out and two's-complement overflow. The carry chain is built from explicit 1-bit full-adder cells, so carry propagates bit 0 → bit N−1. It is the arithmetic leaf of the datapath: operands are sampled on a clock edge and results are presented one cycle later with a valid flag.

## Interface
- `WIDTH`, default 4: operand/sum width in bits; must be ≥ 1.
- `clk`  in  1: clock; rising edge active.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operands `A`, `B`, `cin` are valid this cycle.
- `A`  in  WIDTH: operand A, unsigned or two's-complement.
- `B`  in  WIDTH: operand B, unsigned or two's-complement.
- `cin`  in  1: carry into bit 0.
- `s`  out  WIDTH: registered sum bits `(A + B + cin) mod 2^WIDTH`.
- `cout`  out  1: registered carry out of bit WIDTH−1 (unsigned overflow).
- `ovf`  out  1: registered signed overflow, `c[WIDTH] XOR c[WIDTH−1]`.
- `out_valid`  out  1: `s`/`cout`/`ovf` hold a result computed from a valid input.

## Operation
- Full-adder cell: `sum = a ^ b ^ c`; `carry = (a & b) | (c & (a ^ b))`.
- Cell i takes `A[i]`, `B[i]`, `c[i]` and produces `s_comb[i]`, `c[i+1]`; `c[0] = cin`.
- Instantiate cells with a generate loop; no `+` operator in the datapath.
- `cout_comb = c[WIDTH]`; `ovf_comb = c[WIDTH] ^ c[WIDTH−1]`.
- The block has no signedness input: the same bits serve both views. Use `cout` for unsigned results and `ovf` for signed results.
- On a clock edge with `in_valid=1`, the block registers `s_comb`, `cout_comb` and `ovf_comb`.
- On a clock edge with `in_valid=0`, `s`, `cout` and `ovf` hold their previous values.
- `out_valid` is `in_valid` delayed by one register.
- There is no back-pressure: every valid input produces exactly one valid output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k; they are visible during cycle k+1.
- Throughput: one operation per cycle.
- `rst_n` low drives `s=0`, `cout=0`, `ovf=0`, `out_valid=0` immediately, independent of `clk`.
- Release `rst_n` synchronously to `clk` externally. The first sample is taken on the first rising edge after release.
- If reset asserts mid-operation, the in-flight result is discarded and `out_valid` goes to 0.
- Critical path: `cin`/`A[0]` through WIDTH carry cells to the `cout` and `ovf` registers.
- Boundary cases:
  - All-ones + 0 + `cin=1` wraps `s` to 0 with `cout=1`.
  - Max positive + 1 sets `ovf=1` and `cout=0`.
  - Min negative + min negative sets `ovf=1` and `cout=1`.

## Test plan
All cases use WIDTH=4.
- Reset: hold `rst_n=0` with random inputs and toggling `clk` → `s=0`, `cout=0`, `ovf=0`, `out_valid=0` throughout.
- Basic: A=0, B=0, cin=0, `in_valid=1` → next cycle `s=0000`, `cout=0`, `ovf=0`, `out_valid=1`. Then A=1, B=3 → `s=0100`, `cout=0`, `ovf=0`.
- Signed mix: A=−3 (1101), B=5 (0101), cin=0 → `s=0010` (+2), `cout=1`, `ovf=0`. Then A=2 (0010), B=−5 (1011) → `s=1101` (−3), `cout=0`, `ovf=0`.
- Overflow and carry:
  - A=7, B=1 → `s=1000`, `ovf=1`, `cout=0`.
  - A=1000, B=1000 → `s=0000`, `ovf=1`, `cout=1`.
  - A=1111, B=0000, cin=1 → `s=0000`, `cout=1`, `ovf=0`.
- Hold and valid: drop `in_valid` for 3 cycles while changing A/B → `s`/`cout`/`ovf` unchanged and `out_valid=0`. Then assert reset mid-stream → all outputs 0 asynchronously.
- Exhaustive: all 512 combinations of A, B and cin, pipelined back-to-back → every result matches `{cout,s} = A+B+cin`, and `ovf` matches the signed-range check.
